fetch_sequencer: RTL
====================

Name: fetch_sequencer

Overview:
Controls the PC for the fetch stage and shares the instruction memory between normal fetch and the debug loader. It produces the fetch PC and fetch-valid qualifier, applies branch/jump redirects and pipeline stalls, and supports halt/resume. It sits between the execute/hazard logic and the instruction memory, and replaces ad-hoc PC start-up logic with an explicit state machine.

Parameters:
XLEN, 32, datapath/address width
RESET_VECTOR, 32'h0000_0000, first fetch address after reset (must be 4-byte aligned)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous, active-high reset
stall  input  1  hazard unit: hold PC, re-present same fetch
redirect_valid  input  1  branch/jump taken this cycle
redirect_target  input  XLEN  new PC on redirect
halt_req  input  1  request to halt fetch
resume  input  1  leave HALT
dbg_wr_en  input  1  debug loader write request
dbg_addr  input  XLEN  debug write address
dbg_instr  input  XLEN  debug write data
fetch_pc  output  XLEN  registered PC; also drives instruction memory read address
fetch_valid  output  1  fetch_pc/instruction are a real fetch this cycle
imem_wr_en  output  1  instruction memory write enable
imem_wr_addr  output  XLEN  instruction memory write address
imem_wr_data  output  XLEN  instruction memory write data
halted  output  1  state == HALT
misalign  output  1  one-cycle pulse: redirect_target[1:0] != 0

Behaviour:
- Reset (rst=1): state=IDLE, fetch_pc=RESET_VECTOR, fetch_valid=0, halted=0, misalign=0, imem_wr_en=0.
- FSM states: IDLE, RUN, HALT, DBG. fetch_valid = (state==RUN). All outputs except imem_wr_* are registered.
- IDLE: first cycle after rst deasserts. Next state is DBG if dbg_wr_en, else RUN. PC stays at RESET_VECTOR, so the first valid fetch is RESET_VECTOR, followed by +4 per cycle.
- RUN priority, highest first:
  - dbg_wr_en: go to DBG, PC held.
  - redirect_valid: fetch_pc <= {target[XLEN-1:2],2'b00}; the redirect wins over a simultaneous stall.
  - halt_req: go to HALT, PC held. Execution resumes at the held PC.
  - stall: PC held, fetch_valid stays 1.
  - otherwise: fetch_pc <= fetch_pc + 4, modulo 2^XLEN (wraps FFFF_FFFC -> 0).
- DBG:
  - Entry state (RUN or HALT) is saved in ret_state.
  - While dbg_wr_en=1, stay in DBG. On dbg_wr_en=0, return to ret_state next cycle; the PC is not advanced.
- HALT:
  - dbg_wr_en goes to DBG with ret_state=HALT.
  - Otherwise resume goes to RUN.
  - halt_req and resume asserted together: stay in HALT.
- Redirects in DBG or HALT still update fetch_pc, but fetch_valid stays 0.
- Write port, combinational pass-through: imem_wr_en=dbg_wr_en, imem_wr_addr=dbg_addr, imem_wr_data=dbg_instr.
  - Debug writes are accepted in any state except during rst.
  - They always win over fetch, because fetch is suspended in DBG.
- misalign: registered pulse one cycle after a redirect with target[1:0]!=0, in any state.
- rst mid-operation: any state returns to IDLE on the next edge. Pending halt/redirect is discarded.

Optional Feature:
Macro FETCH_PERF_CNT_EN.
- Defined: adds outputs perf_fetch_cnt [31:0] and perf_stall_cnt [31:0].
  - perf_fetch_cnt increments on each RUN cycle with stall=0 and no dbg/halt exit.
  - perf_stall_cnt increments on each RUN cycle with stall=1.
  - Both wrap at 2^32 and clear on rst.
- Undefined: ports and counters are absent. All other behaviour is identical.

Decomposition:
- Package fetch_pkg:
  - typedef enum logic [1:0] fetch_state_t {IDLE, RUN, HALT, DBG}
  - localparam INSTR_BYTES = 4
- The counter pair under FETCH_PERF_CNT_EN is a natural sub-module: fetch_perf_counters. Everything else stays in one module.

Test Plan:
- Reset, then release, 4 cycles, no stalls -> fetch_valid 0 on first cycle; fetch_pc 0,4,8,C on the following cycles with fetch_valid=1.
- stall=1 for 2 cycles at PC 0x8 -> fetch_pc stays 0x8 with valid=1, then 0xC.
- redirect_valid with target 0x100 and stall=1 in the same cycle -> next fetch_pc=0x100. redirect to 0x102 -> fetch_pc=0x100, misalign pulses 1 cycle.
- In RUN at PC 0x10, dbg_wr_en for 3 cycles (addr 0x40, data 0x00500093) -> imem_wr_* mirror inputs, fetch_valid=0, PC held 0x10. Resumes RUN at 0x10, then 0x14.
- Halt and resume: halt_req at PC 0x20 -> halted=1, valid=0. Then dbg write -> DBG, returns to HALT. Then resume -> RUN at 0x20. halt_req and resume together in HALT -> stays halted.
- rst asserted mid-RUN at PC 0x80 -> next cycle IDLE, fetch_pc=RESET_VECTOR. With FETCH_PERF_CNT_EN: 5 fetches and 2 stalls -> counts 5 and 2, cleared by rst.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch sequencer.
package fetch_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2,
      DBG  = 2'd3
   } fetch_state_t;

   localparam int unsigned INSTR_BYTES = 4;
   localparam int unsigned PERF_W      = 32;

endpackage

// File: rtl/fetch_perf_counters.sv
// Free-running fetch/stall event counters; wrap at 2^PERF_W, clear on rst.
module fetch_perf_counters
   import fetch_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              fetch_inc,
   input  logic              stall_inc,
   output logic [PERF_W-1:0] perf_fetch_cnt,
   output logic [PERF_W-1:0] perf_stall_cnt
);

   always_ff @(posedge clk) begin
      if (rst) begin
         perf_fetch_cnt <= '0;
         perf_stall_cnt <= '0;
      end else begin
         if (fetch_inc) perf_fetch_cnt <= perf_fetch_cnt + PERF_W'(1);
         if (stall_inc) perf_stall_cnt <= perf_stall_cnt + PERF_W'(1);
      end
   end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch PC sequencer with halt/resume and a debug loader sharing imem.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_sequencer
   import fetch_pkg::*;
#(
   parameter int unsigned     XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(32'h0000_0000)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_target,
   input  logic            halt_req,
   input  logic            resume,
   input  logic            dbg_wr_en,
   input  logic [XLEN-1:0] dbg_addr,
   input  logic [XLEN-1:0] dbg_instr,
   output logic [XLEN-1:0] fetch_pc,
   output logic            fetch_valid,
   output logic            imem_wr_en,
   output logic [XLEN-1:0] imem_wr_addr,
   output logic [XLEN-1:0] imem_wr_data,
   output logic            halted,
   output logic            misalign
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [PERF_W-1:0] perf_fetch_cnt,
   output logic [PERF_W-1:0] perf_stall_cnt
`endif
);

   fetch_state_t    state, state_d;
   fetch_state_t    ret_state, ret_d;
   logic [XLEN-1:0] pc_d;
   logic [XLEN-1:0] redirect_pc;

   assign redirect_pc = {redirect_target[XLEN-1:2], 2'b00};

   // Debug loader drives the imem write port directly; suppressed only in reset.
   assign imem_wr_en   = dbg_wr_en & ~rst;
   assign imem_wr_addr = dbg_addr;
   assign imem_wr_data = dbg_instr;

   always_comb begin
      state_d = state;
      ret_d   = ret_state;
      pc_d    = fetch_pc;
      unique case (state)
         IDLE: begin
            if (dbg_wr_en) begin
               state_d = DBG;
               ret_d   = RUN;
            end else begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (dbg_wr_en) begin
               state_d = DBG;
               ret_d   = RUN;
            end else if (redirect_valid) begin
               pc_d = redirect_pc;
            end else if (halt_req) begin
               state_d = HALT;
            end else if (!stall) begin
               pc_d = fetch_pc + XLEN'(INSTR_BYTES);
            end
         end
         HALT: begin
            if (redirect_valid) pc_d = redirect_pc;
            if (dbg_wr_en) begin
               state_d = DBG;
               ret_d   = HALT;
            end else if (resume && !halt_req) begin
               state_d = RUN;
            end
         end
         DBG: begin
            if (redirect_valid) pc_d = redirect_pc;
            if (!dbg_wr_en) state_d = ret_state;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         ret_state   <= RUN;
         fetch_pc    <= RESET_VECTOR;
         fetch_valid <= 1'b0;
         halted      <= 1'b0;
         misalign    <= 1'b0;
      end else begin
         state       <= state_d;
         ret_state   <= ret_d;
         fetch_pc    <= pc_d;
         fetch_valid <= (state_d == RUN);
         halted      <= (state_d == HALT);
         misalign    <= redirect_valid && (redirect_target[1:0] != 2'b00);
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic fetch_inc;
   logic stall_inc;
   logic run_exit;

   // A RUN cycle leaving for DBG or HALT is not counted as a fetch.
   assign run_exit  = dbg_wr_en || (halt_req && !redirect_valid);
   assign fetch_inc = (state == RUN) && !stall && !run_exit;
   assign stall_inc = (state == RUN) && stall;

   fetch_perf_counters u_perf (
      .clk            (clk),
      .rst            (rst),
      .fetch_inc      (fetch_inc),
      .stall_inc      (stall_inc),
      .perf_fetch_cnt (perf_fetch_cnt),
      .perf_stall_cnt (perf_stall_cnt)
   );
`endif

endmodule
